// File: rtl/draw_board_if.sv
// VGA pixel bundle passed between pixel-pipeline stages.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_board.sv
// Overlays a GRID_SIZE x GRID_SIZE warships board on the VGA stream; two-stage
// pipeline, cell state fetched from an external board memory addressed in stage 1.
module draw_board #(
    parameter int          X_POS     = 64,
    parameter int          Y_POS     = 64,
    parameter int          CELL_SIZE = 32,
    parameter int          GRID_SIZE = 10,
    parameter int          ADDR_W    = $clog2(GRID_SIZE*GRID_SIZE),
    parameter logic [11:0] COL_LINE  = 12'h000,
    parameter logic [11:0] COL_WATER = 12'h05F,
    parameter logic [11:0] COL_SHIP  = 12'h888,
    parameter logic [11:0] COL_HIT   = 12'hF00,
    parameter logic [11:0] COL_MISS  = 12'hFFF
) (
    input  logic              clk,
    input  logic              rst,
    vga_if.in                 in,
    vga_if.out                out,
    output logic [ADDR_W-1:0] cell_addr,
    input  logic [1:0]        cell_data
);
    localparam int BOARD_PX = GRID_SIZE*CELL_SIZE;
    localparam int COL_W    = (GRID_SIZE > 1) ? $clog2(GRID_SIZE) : 1;
    localparam int PX_W     = $clog2(CELL_SIZE);

    localparam logic [10:0]      X_FIRST = 11'(X_POS);
    localparam logic [10:0]      X_END   = 11'(X_POS + BOARD_PX);
    localparam logic [10:0]      X_LAST  = 11'(X_POS + BOARD_PX - 1);
    localparam logic [10:0]      Y_FIRST = 11'(Y_POS);
    localparam logic [10:0]      Y_END   = 11'(Y_POS + BOARD_PX);
    localparam logic [10:0]      Y_LAST  = 11'(Y_POS + BOARD_PX - 1);
    localparam logic [COL_W-1:0] IDX_MAX = COL_W'(GRID_SIZE - 1);
    localparam logic [PX_W-1:0]  PX_MAX  = PX_W'(CELL_SIZE - 1);

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } pix_t;

    pix_t              in_pix;
    pix_t              s1_d, s1_q, s2_d, s2_q;
    logic              in_board_d, in_board_q;
    logic              line_d, line_q;
    logic              h_in, v_in;
    logic [COL_W-1:0]  col_d, col_q, col_cur;
    logic [COL_W-1:0]  row_d, row_q;
    logic [PX_W-1:0]   col_px_d, col_px_q, col_px_cur;
    logic [PX_W-1:0]   row_px_d, row_px_q;
    logic [ADDR_W-1:0] cell_addr_d, cell_addr_q;

    assign in_pix = {in.hcount, in.vcount, in.hsync, in.vsync, in.hblnk, in.vblnk, in.rgb};

    always_comb begin
        s1_d = in_pix;
        h_in = (in.hcount >= X_FIRST) && (in.hcount < X_END);
        v_in = (in.vcount >= Y_FIRST) && (in.vcount < Y_END);
        in_board_d = h_in && v_in && !in.hblnk && !in.vblnk;

        // col/col_px registers hold the position of the *next* pixel; the current
        // pixel's position is forced to zero at the board's left edge.
        col_cur    = (in.hcount == X_FIRST) ? '0 : col_q;
        col_px_cur = (in.hcount == X_FIRST) ? '0 : col_px_q;
        col_d      = col_q;
        col_px_d   = col_px_q;
        if (h_in) begin
            if (col_px_cur == PX_MAX) begin
                col_px_d = '0;
                col_d    = (col_cur == IDX_MAX) ? col_cur : col_cur + COL_W'(1);
            end else begin
                col_px_d = col_px_cur + PX_W'(1);
                col_d    = col_cur;
            end
        end

        row_d    = row_q;
        row_px_d = row_px_q;
        if (in.hcount == 11'd0) begin
            if (in.vcount == Y_FIRST) begin
                row_d    = '0;
                row_px_d = '0;
            end else if (row_px_q == PX_MAX) begin
                row_px_d = '0;
                row_d    = (row_q == IDX_MAX) ? row_q : row_q + COL_W'(1);
            end else begin
                row_px_d = row_px_q + PX_W'(1);
            end
        end

        line_d = in_board_d && ((col_px_cur == '0) || (row_px_d == '0) ||
                                (in.hcount == X_LAST) || (in.vcount == Y_LAST));

        cell_addr_d = in_board_d
                    ? ADDR_W'(row_d) * ADDR_W'(GRID_SIZE) + ADDR_W'(col_cur)
                    : cell_addr_q;

        s2_d = s1_q;
        if (s1_q.hblnk || s1_q.vblnk) begin
            s2_d.rgb = 12'h000;
        end else if (!in_board_q) begin
            s2_d.rgb = s1_q.rgb;
        end else if (line_q) begin
            s2_d.rgb = COL_LINE;
        end else begin
            case (cell_data)
                2'd0:    s2_d.rgb = COL_WATER;
                2'd1:    s2_d.rgb = COL_SHIP;
                2'd2:    s2_d.rgb = COL_HIT;
                default: s2_d.rgb = COL_MISS;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            in_board_q  <= 1'b0;
            line_q      <= 1'b0;
            col_q       <= '0;
            col_px_q    <= '0;
            row_q       <= '0;
            row_px_q    <= '0;
            cell_addr_q <= '0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            in_board_q  <= in_board_d;
            line_q      <= line_d;
            col_q       <= col_d;
            col_px_q    <= col_px_d;
            row_q       <= row_d;
            row_px_q    <= row_px_d;
            cell_addr_q <= cell_addr_d;
        end
    end

    assign cell_addr  = cell_addr_q;
    assign out.hcount = s2_q.hcount;
    assign out.vcount = s2_q.vcount;
    assign out.hsync  = s2_q.hsync;
    assign out.vsync  = s2_q.vsync;
    assign out.hblnk  = s2_q.hblnk;
    assign out.vblnk  = s2_q.vblnk;
    assign out.rgb    = s2_q.rgb;
endmodule

// File: tb/tb_draw_board.sv
// Bench for draw_board: sparse raster stimulus, scoreboard of expected output
// pixels built from a coordinate-division reference model of the board.
module tb_draw_board;
    localparam int H_ACT  = 448;
    localparam int HS_BEG = 460;
    localparam int HS_END = 470;
    localparam int V_ACT  = 400;
    localparam int VS_BEG = 402;
    localparam int VS_END = 404;
    localparam int V_TOT  = 410;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] cell_addr;
    logic [1:0] cell_data;
    exp_t       sb[$];
    logic [6:0] exp_addr = 7'd0;
    int         errors = 0;
    int         checks = 0;
    int         frame_no = 0;

    vga_if vin();
    vga_if vout();

    always #5 clk = ~clk;

    function automatic logic [1:0] mem_fn(input logic [6:0] a);
        return (a == 7'd23) ? 2'd1 : a[1:0];
    endfunction

    // Board memory: data for the registered address is ready by the next edge.
    assign cell_data = mem_fn(cell_addr);

    draw_board dut (
        .clk       (clk),
        .rst       (rst),
        .in        (vin),
        .out       (vout),
        .cell_addr (cell_addr),
        .cell_data (cell_data)
    );

    function automatic bit in_board_m(input int h, input int v, input bit hb, input bit vb);
        return (h >= 64) && (h < 384) && (v >= 64) && (v < 384) && !hb && !vb;
    endfunction

    function automatic logic [6:0] addr_m(input int h, input int v);
        return 7'(((v - 64) / 32) * 10 + (h - 64) / 32);
    endfunction

    function automatic logic [11:0] cell_col(input logic [1:0] s);
        case (s)
            2'd0:    return 12'h05F;
            2'd1:    return 12'h888;
            2'd2:    return 12'hF00;
            default: return 12'hFFF;
        endcase
    endfunction

    function automatic exp_t model(input int h, input int v, input bit hs, input bit vs,
                                   input bit hb, input bit vb, input logic [11:0] up);
        exp_t e;
        bit   ln;
        e.h = 11'(h);
        e.v = 11'(v);
        e.hs = hs;
        e.vs = vs;
        e.hb = hb;
        e.vb = vb;
        ln = ((h - 64) % 32 == 0) || ((v - 64) % 32 == 0) || (h == 383) || (v == 383);
        if (hb || vb)                     e.rgb = 12'h000;
        else if (!in_board_m(h, v, hb, vb)) e.rgb = up;
        else if (ln)                      e.rgb = 12'h000;
        else                              e.rgb = cell_col(mem_fn(addr_m(h, v)));
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int h, input int v, input bit fb, input bit r);
        bit          hb, vb, hs, vs;
        logic [11:0] up;
        exp_t        e;
        string       at;
        hb = (h >= H_ACT) || fb;
        vb = (v >= V_ACT);
        hs = (h >= HS_BEG) && (h < HS_END);
        vs = (v >= VS_BEG) && (v < VS_END);
        up = ((h == 10 && v == 10) || (h == 400 && v == 200)) ? 12'hABC : {6'(h), 6'(v)};
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.hsync  = hs;
        vin.vsync  = vs;
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.rgb    = up;
        rst        = r;
        if (!r) begin
            sb.push_back(model(h, v, hs, vs, hb, vb, up));
            if (in_board_m(h, v, hb, vb)) exp_addr = addr_m(h, v);
        end
        @(posedge clk);
        #1;
        if (r) begin
            chk("rst_hcount", 32'(vout.hcount), 32'd0);
            chk("rst_vcount", 32'(vout.vcount), 32'd0);
            chk("rst_sync",   32'({vout.hsync, vout.vsync}), 32'd0);
            chk("rst_blnk",   32'({vout.hblnk, vout.vblnk}), 32'd0);
            chk("rst_rgb",    32'(vout.rgb), 32'd0);
            chk("rst_addr",   32'(cell_addr), 32'd0);
            sb.delete();
            sb.push_back('0);
            exp_addr = 7'd0;
        end else begin
            e  = sb.pop_front();
            at = $sformatf("@%0d,%0d", e.h, e.v);
            chk({"hcount", at}, 32'(vout.hcount), 32'(e.h));
            chk({"vcount", at}, 32'(vout.vcount), 32'(e.v));
            chk({"sync", at},   32'({vout.hsync, vout.vsync}), 32'({e.hs, e.vs}));
            chk({"blnk", at},   32'({vout.hblnk, vout.vblnk}), 32'({e.hb, e.vb}));
            chk({"rgb", at},    32'(vout.rgb), 32'(e.rgb));
            chk($sformatf("cell_addr@%0d,%0d", h, v), 32'(cell_addr), 32'(exp_addr));
            if (h == 165 && v == 133) chk("addr_23", 32'(cell_addr), 32'd23);
            if (frame_no == 3 && v == 65 && h == 357) chk("addr_restart_col9", 32'(cell_addr), 32'd9);
            if (frame_no == 3 && v == 65 && h == 69)  chk("addr_restart_col0", 32'(cell_addr), 32'd0);
            if (e.h == 165 && e.v == 133) chk("rgb_ship", 32'(vout.rgb), 32'h888);
            if (e.h == 100 && e.v == 100) chk("rgb_miss", 32'(vout.rgb), 32'hFFF);
            if (e.h == 68 && e.v == 68)   chk("rgb_water", 32'(vout.rgb), 32'h05F);
            if (!e.hb && e.v == 133 && (e.h == 64 || e.h == 96 || e.h == 383))
                chk({"rgb_vline", at}, 32'(vout.rgb), 32'h000);
            if (!e.hb && (e.v == 64 || e.v == 383) && e.h == 200)
                chk({"rgb_hline", at}, 32'(vout.rgb), 32'h000);
            if ((e.h == 10 && e.v == 10) || (e.h == 400 && e.v == 200))
                chk({"rgb_outside", at}, 32'(vout.rgb), e.hb ? 32'h000 : 32'hABC);
        end
    endtask

    task automatic run_line(input int v, input bit full);
        for (int h = 0; h < 3; h++) step(h, v, 1'b0, 1'b0);
        if (full) for (int h = 60; h < 480; h++) step(h, v, 1'b0, 1'b0);
    endtask

    initial begin
        step(0, 0, 1'b0, 1'b1);
        step(0, 0, 1'b0, 1'b1);

        frame_no = 1;
        for (int v = 0; v < V_TOT; v++) begin
            run_line(v, v == 64 || v == 68 || v == 96 || v == 100 || v == 133 ||
                        v == 200 || v == 383 || v == 384 || v == 403);
            if (v == 10) begin
                step(10, 10, 1'b0, 1'b0);
                step(10, 10, 1'b1, 1'b0);
            end
            if (v == 200) step(400, 200, 1'b1, 1'b0);
        end

        frame_no = 2;
        for (int v = 0; v < 200; v++) run_line(v, 1'b0);
        run_line(200, 1'b0);
        for (int h = 60; h <= 150; h++) step(h, 200, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(151 + i, 200, 1'b0, 1'b1);
        for (int h = 400; h < 480; h++) step(h, 200, 1'b0, 1'b0);
        for (int v = 201; v < V_TOT; v++) run_line(v, 1'b0);

        frame_no = 3;
        for (int v = 0; v <= 70; v++) run_line(v, v == 64 || v == 65);
        step(1000, 0, 1'b0, 1'b0);
        step(1000, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/draw_board.md
Name: draw_board

Overview:
- Pixel-pipeline stage directly downstream of the VGA timing generator; consumes its vga_if bundle (hcount, vcount, hsync, vsync, hblnk, vblnk, rgb) and produces a new vga_if bundle.
- Overlays one GRID_SIZE x GRID_SIZE warships board at a fixed screen position.
- Fetches each cell's 2-bit state from an external synchronous board memory.
- Colours water, ship, hit, miss and grid lines; passes all other pixels through unchanged.

Parameters:
- X_POS, 64, left edge of board in pixels (hcount value of first grid pixel)
- Y_POS, 64, top edge of board in lines
- CELL_SIZE, 32, cell pitch in pixels, >= 2
- GRID_SIZE, 10, cells per row and per column
- ADDR_W, $clog2(GRID_SIZE*GRID_SIZE), cell address width (7 at defaults)
- COL_LINE, 12'h000, grid line colour
- COL_WATER, 12'h05F; COL_SHIP, 12'h888; COL_HIT, 12'hF00; COL_MISS, 12'hFFF — cell colours

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- in  vga_if.in  -  timing/colour bundle from upstream
- out  vga_if.out  -  bundle to downstream, delayed 2 cycles
- cell_addr  out  ADDR_W  board memory read address = row*GRID_SIZE + col
- cell_data  in  2  memory read data, valid exactly 1 cycle after cell_addr; encoding 0=water, 1=ship, 2=hit, 3=miss

Behaviour:
- One clock, synchronous active-high reset. On reset, all out fields (hcount, vcount, hsync, vsync, hblnk, vblnk, rgb), cell_addr, all pipeline registers and all counters go to 0. Reset mid-frame: outputs are 0 on the cycle after rst is sampled high. Tracking resumes correctly from the next board row start (vcount == Y_POS at hcount == 0).
- Latency: every out field equals the corresponding in field delayed exactly 2 clocks. No combinational path from in to out.
- Stage 1 (registered): cell_addr, in_board flag, line flag, delayed in bundle.
- Stage 2 (registered): final rgb select using cell_data, delayed bundle.
- Column tracking uses counters, not division:
  - when in.hcount == X_POS: col=0, col_px=0.
  - else while in board horizontally: col_px increments; when col_px == CELL_SIZE-1 it wraps to 0 and col increments.
- Row tracking is evaluated only on cycles with in.hcount == 0:
  - if in.vcount == Y_POS: row=0, row_px=0.
  - else if row_px == CELL_SIZE-1: row_px=0, row++.
  - else row_px++.
  - Row counters hold when hcount != 0.
- in_board = X_POS <= hcount < X_POS+GRID_SIZE*CELL_SIZE AND Y_POS <= vcount < Y_POS+GRID_SIZE*CELL_SIZE AND !hblnk AND !vblnk.
- line flag = in_board AND (col_px == 0 OR row_px == 0 OR hcount == X_POS+GRID_SIZE*CELL_SIZE-1 OR vcount == Y_POS+GRID_SIZE*CELL_SIZE-1).
- cell_addr is updated every cycle with row*GRID_SIZE+col when in_board, and holds its previous value otherwise.
- rgb priority at stage 2:
  1. hblnk or vblnk (delayed) → 12'h000
  2. !in_board → delayed in.rgb
  3. line → COL_LINE
  4. otherwise → colour decoded from cell_data
- Counters must not overflow; max row/col value is GRID_SIZE-1. Widths are $clog2 of GRID_SIZE and CELL_SIZE. Board extending past the active area is legal; blanking forces black.

Test Plan:
- Reset then free-run with timing generator: out.hsync/vsync/hblnk/vblnk/hcount/vcount equal in.* delayed exactly 2 cycles for a full frame; all outputs 0 during and one cycle after rst.
- in.hcount=165, vcount=133 (cell col 3, row 2, px offset 5,5) with memory returning 1 at addr 23 → cell_addr==23 one cycle later, out.rgb==12'h888 with out.hcount==165.
- Memory model returning addr%4: pixel (hcount=100, vcount=100) → addr 11 → state 3 → out.rgb==12'hFFF; pixel (hcount=68, vcount=68) → addr 0 → out.rgb==12'h05F.
- Grid lines: hcount=64, 96, 383 and vcount=64, 383 inside board → out.rgb==12'h000 (COL_LINE) regardless of cell_data.
- Outside board: upstream rgb forced to 12'hABC, pixel (10,10) and (400,200) → out.rgb==12'hABC; same pixels inside blanking → 12'h000.
- Assert rst at vcount=200 mid-line for 3 cycles, release → outputs 0, then first board row after next vcount==64 renders with row 0 addresses 0..9, identical to an uninterrupted frame.
